apb_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single request port of the APB bridge master between `NREQ` requesters, such as the SPI controller and a debug/config agent. It selects one requester and latches its address, direction and write data. It presents that transfer to the master's request side, tracks the master's `ack` and `complete` pulses, and returns per-requester accept/done pulses and read data. Only one transfer is outstanding at a time.

---
 rtl/apb_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Arbitrates NREQ requesters onto the single request port of an APB bridge master.
// Round-robin by default; define APB_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module apb_req_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 16,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NREQ-1:0]      cli_req,
  input  logic [NREQ-1:0]      cli_wr,
  input  logic [NREQ*AW-1:0]   cli_addr,
  input  logic [NREQ*DW-1:0]   cli_wdata,
  output logic [NREQ-1:0]      cli_ack,
  output logic [NREQ-1:0]      cli_done,
  output logic [DW-1:0]        cli_rdata,
  output logic                 m_req,
  output logic                 m_wr,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_wdata,
  input  logic                 m_ack,
  input  logic                 m_complete,
  input  logic [DW-1:0]        m_rdata,
  output logic                 busy,
  output logic [IW-1:0]        owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              m_req_q, m_req_d;
  logic              m_wr_q, m_wr_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;
  logic [NREQ-1:0]   cli_ack_q, cli_ack_d;
  logic [NREQ-1:0]   cli_done_q, cli_done_d;
  logic [DW-1:0]     cli_rdata_q, cli_rdata_d;
  logic              busy_q, busy_d;
  logic [IW-1:0]     win;

`ifdef APB_ARB_FIXED_PRIO_EN
  function automatic logic [IW-1:0] pick_winner(input logic [NREQ-1:0] req);
    logic [IW-1:0] sel;
    logic          found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        sel   = IW'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign win = pick_winner(cli_req);
`else
  // Search starts just after the last completed owner and wraps around.
  function automatic logic [IW-1:0] pick_winner(input logic [NREQ-1:0] req,
                                                input logic [IW-1:0]   last);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign win = pick_winner(cli_req, last_q);
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    m_req_d     = m_req_q;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    cli_ack_d   = '0;
    cli_done_d  = '0;
    cli_rdata_d = cli_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (|cli_req) begin
          state_d   = S_ISSUE;
          m_req_d   = 1'b1;
          m_wr_d    = cli_wr[win];
          m_addr_d  = cli_addr[int'(win)*AW +: AW];
          m_wdata_d = cli_wdata[int'(win)*DW +: DW];
          owner_d   = win;
        end
      end
      S_ISSUE: begin
        if (m_ack) begin
          m_req_d   = 1'b0;
          cli_ack_d = NREQ'(1) << owner_q;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_complete) begin
          cli_done_d = NREQ'(1) << owner_q;
          if (!m_wr_q) begin
            cli_rdata_d = m_rdata;
          end
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(NREQ - 1);
      owner_q     <= '0;
      m_req_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      cli_ack_q   <= '0;
      cli_done_q  <= '0;
      cli_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      m_req_q     <= m_req_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      cli_ack_q   <= cli_ack_d;
      cli_done_q  <= cli_done_d;
      cli_rdata_q <= cli_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign cli_ack   = cli_ack_q;
  assign cli_done  = cli_done_q;
  assign cli_rdata = cli_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: behavioural APB master and requesters with a
// round-robin/fixed-priority reference model; directed cases then random traffic.
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int IW   = 2;

  logic                pclk = 1'b0;
  logic                presetn = 1'b0;
  logic [NREQ-1:0]     cli_req = '0;
  logic [NREQ-1:0]     cli_wr = '0;
  logic [NREQ*AW-1:0]  cli_addr = '0;
  logic [NREQ*DW-1:0]  cli_wdata = '0;
  logic [NREQ-1:0]     cli_ack;
  logic [NREQ-1:0]     cli_done;
  logic [DW-1:0]       cli_rdata;
  logic                m_req;
  logic                m_wr;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_wdata;
  logic                m_ack = 1'b0;
  logic                m_complete = 1'b0;
  logic [DW-1:0]       m_rdata = '0;
  logic                busy;
  logic [IW-1:0]       owner;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .pclk(pclk), .presetn(presetn),
    .cli_req(cli_req), .cli_wr(cli_wr), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
    .cli_ack(cli_ack), .cli_done(cli_done), .cli_rdata(cli_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_complete(m_complete), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 pclk = ~pclk;

  int nchk = 0;
  int nerr = 0;

  // Requester model
  logic [NREQ-1:0] pend = '0;
  logic [AW-1:0]   f_addr [NREQ];
  logic [DW-1:0]   f_wdata[NREQ];
  logic            f_wr   [NREQ];
  bit              cont = 0;

  // Master / arbitration model
  int          mph = 0;
  int          cnt = 0;
  int          wst = 0;
  int          cur = 0;
  int          last_m = NREQ - 1;
  logic        cur_wr = 1'b0;
  logic [DW-1:0] sent_rd = '0;
  logic [DW-1:0] prev_rd = '0;
  bit          rd_force = 0;
  logic [DW-1:0] rd_force_val = '0;
  int          cyc = 0;
  int          gcyc = 0;
  int          glog[$];
  int          nrise = 0;
  logic        mreq_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int lst);
`ifdef APB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic drive();
    cli_req = pend;
    for (int i = 0; i < NREQ; i++) begin
      cli_wr[i] = f_wr[i];
      cli_addr[i*AW +: AW] = f_addr[i];
      cli_wdata[i*DW +: DW] = f_wdata[i];
    end
  endtask

  task automatic new_fields(input int i);
    f_addr[i]  = AW'($urandom);
    f_wdata[i] = DW'($urandom);
    f_wr[i]    = 1'($urandom_range(0, 1));
  endtask

  // One cycle: sample at the falling edge, check against the model, drive next inputs.
  task automatic tick();
    int exp;
    @(negedge pclk);
    cyc++;
    if (m_req && !mreq_prev) nrise++;
    mreq_prev = m_req;
    case (mph)
      0: begin
        check("pulses_idle", 32'({cli_ack, cli_done}), 32'd0);
        check("m_req_grant", 32'(m_req), 32'(|pend));
        if (m_req) begin
          exp = pick(pend, last_m);
          check("grant_owner", 32'(owner), 32'(exp));
          check("grant_busy", 32'(busy), 32'd1);
          if (exp >= 0) begin
            check("grant_addr", 32'(m_addr), 32'(f_addr[exp]));
            check("grant_wr", 32'(m_wr), 32'(f_wr[exp]));
            if (f_wr[exp]) check("grant_wdata", 32'(m_wdata), 32'(f_wdata[exp]));
            cur_wr = f_wr[exp];
          end
          cur = exp;
          gcyc = cyc;
          glog.push_back(exp);
          mph = 1;
        end else begin
          check("busy_idle", 32'(busy), 32'd0);
        end
      end
      1: begin
        check("m_req_hold", 32'(m_req), 32'd1);
        check("ack_early", 32'(cli_ack), 32'd0);
        m_ack = 1'b1;
        mph = 2;
      end
      2: begin
        m_ack = 1'b0;
        check("m_req_drop", 32'(m_req), 32'd0);
        check("cli_ack", 32'(cli_ack), 32'(1) << cur);
        check("busy_ack", 32'(busy), 32'd1);
        if (cont) new_fields(cur);
        else pend[cur] = 1'b0;
        drive();
        cnt = wst;
        mph = 3;
      end
      3: begin
        check("m_req_wait", 32'(m_req), 32'd0);
        check("pulses_wait", 32'({cli_ack, cli_done}), 32'd0);
        check("busy_wait", 32'(busy), 32'd1);
        if (cnt == 0) begin
          sent_rd = rd_force ? rd_force_val : DW'($urandom);
          m_rdata = sent_rd;
          m_complete = 1'b1;
          mph = 4;
        end else begin
          cnt--;
        end
      end
      default: begin
        m_complete = 1'b0;
        m_rdata = DW'($urandom);
        check("cli_done", 32'(cli_done), 32'(1) << cur);
        if (!cur_wr) prev_rd = sent_rd;
        check("cli_rdata", 32'(cli_rdata), 32'(prev_rd));
        check("busy_done", 32'(busy), 32'd0);
        check("m_req_done", 32'(m_req), 32'd0);
        check("done_latency", 32'(cyc - gcyc), 32'(4 + wst));
        last_m = cur;
        mph = 0;
      end
    endcase
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(mph == 0 && pend == '0 && !m_req) && n < 300);
    check({tag, "_timeout"}, 32'(n < 300), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_req"}, 32'(m_req), 32'd0);
    check({tag, "_m_wr"}, 32'(m_wr), 32'd0);
    check({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    check({tag, "_m_wdata"}, 32'(m_wdata), 32'd0);
    check({tag, "_pulses"}, 32'({cli_ack, cli_done}), 32'd0);
    check({tag, "_rdata"}, 32'(cli_rdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    int exp_order[5];
    for (int i = 0; i < NREQ; i++) begin
      f_addr[i] = '0; f_wdata[i] = '0; f_wr[i] = 1'b0;
    end
    drive();
    repeat (3) @(negedge pclk);
    check_reset_vals("rst");
    presetn = 1'b1;
    repeat (2) tick();

    // Single read from requester 2, zero wait states
    f_addr[2] = 16'h0040; f_wr[2] = 1'b0; f_wdata[2] = 16'h5555;
    rd_force = 1; rd_force_val = 16'hBEEF; wst = 0;
    pend[2] = 1'b1; drive();
    wait_idle("rd2");
    check("rd2_owner", 32'(glog[glog.size()-1]), 32'd2);
    check("rd2_rdata", 32'(cli_rdata), 32'hBEEF);

    // Write from requester 0; read data must be left alone
    f_addr[0] = 16'h0010; f_wr[0] = 1'b1; f_wdata[0] = 16'h1234;
    rd_force_val = 16'hDEAD;
    pend[0] = 1'b1; drive();
    wait_idle("wr0");
    check("wr0_rdata_kept", 32'(cli_rdata), 32'hBEEF);
    rd_force = 0;

    // Stray master handshakes while idle are ignored
    m_ack = 1'b1; m_complete = 1'b1;
    tick();
    m_ack = 1'b0; m_complete = 1'b0;
    repeat (3) tick();

    // Three wait states on requester 1
    new_fields(1); f_wr[1] = 1'b0; wst = 3;
    pend[1] = 1'b1; drive();
    wait_idle("ws3");

    // Reset while a transfer sits in WAIT
    new_fields(3); wst = 20;
    pend[3] = 1'b1; drive();
    n = 0;
    while (mph != 3 && n < 40) begin tick(); n++; end
    check("rstw_reach_wait", 32'(mph), 32'd3);
    repeat (2) tick();
    presetn = 1'b0;
    #1;
    check_reset_vals("rstw");
    m_ack = 1'b0; m_complete = 1'b0; mph = 0;
    last_m = NREQ - 1; prev_rd = '0; mreq_prev = 1'b0; wst = 0;
    @(negedge pclk);
    presetn = 1'b1;

    // All requesters held continuously
    base = glog.size();
    for (int i = 0; i < NREQ; i++) new_fields(i);
    pend = '1; cont = 1; drive();
    n = 0;
    while (glog.size() < base + 5 && n < 200) begin tick(); n++; end
    cont = 0;
    check("cont_grants", 32'(glog.size() >= base + 5), 32'd1);
`ifdef APB_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    if (glog.size() >= base + 5)
      for (int k = 0; k < 5; k++) check($sformatf("cont_order%0d", k), 32'(glog[base+k]), 32'(exp_order[k]));
    wait_idle("cont");

    // Random traffic
    for (int c = 0; c < 900; c++) begin
      if (mph == 0) wst = $urandom_range(0, 3);
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 5) == 0) begin
          new_fields(i);
          pend[i] = 1'b1;
        end
      drive();
      tick();
    end
    wait_idle("rand");

    check("issue_once", 32'(nrise), 32'(glog.size()));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
